ws2812_rx: RTL



---
 rtl/ws2812_rx_if.sv | 12 +
 rtl/ws2812_rx.sv | 94 +++++++++
 2 files changed

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: serial input and decoded pixel/frame strobes of the WS2812 receiver
interface ws2812_rx_if;
  logic        din;
  logic [23:0] px_data;
  logic        px_valid;
  logic [7:0]  px_num;
  logic        frame_done;
  logic        bit_err;
  logic        busy;
  modport master (input din, output px_data, px_valid, px_num, frame_done, bit_err, busy);
  modport slave (output din, input px_data, px_valid, px_num, frame_done, bit_err, busy);
endinterface

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 single-wire stream into 24-bit pixels with frame/latch detection
module ws2812_rx #(
  parameter int unsigned BIT1_MIN     = 7,
  parameter int unsigned GLITCH_MAX   = 1,
  parameter int unsigned HIGH_MAX     = 24,
  parameter int unsigned LATCH_CYCLES = 600
) (
  input logic         hwclk,
  input logic         reset_n,
  ws2812_rx_if.master rx
);
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;
  state_t      state;
  logic        s1, s2, s3, from_low;
  logic [7:0]  hcnt, pcnt;
  logic [15:0] lcnt;
  logic [4:0]  bit_cnt;
  logic [22:0] sr;
  logic        rise, fall, b;
  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign b       = hcnt >= 8'(BIT1_MIN);
  assign rx.busy = state != IDLE;
  always_ff @(posedge hwclk or negedge reset_n)
    if (!reset_n) begin
      {s1, s2, s3}  <= 3'b000;
      state         <= SYNC;
      from_low      <= 1'b0;
      hcnt          <= '0;
      pcnt          <= '0;
      lcnt          <= '0;
      bit_cnt       <= '0;
      sr            <= '0;
      rx.px_data    <= '0;
      rx.px_valid   <= 1'b0;
      rx.px_num     <= '0;
      rx.frame_done <= 1'b0;
      rx.bit_err    <= 1'b0;
    end else begin
      {s1, s2, s3}  <= {rx.din, s1, s2};
      rx.px_valid   <= 1'b0;
      rx.frame_done <= 1'b0;
      rx.bit_err    <= 1'b0;
      case (state)
        SYNC:
          if (s2) lcnt <= '0;
          else if (lcnt == 16'(LATCH_CYCLES)) begin
            state   <= IDLE;
            bit_cnt <= '0;
            pcnt    <= '0;
          end else lcnt <= lcnt + 16'd1;
        IDLE:
          if (rise) begin
            state    <= HIGH;
            hcnt     <= 8'd1;
            from_low <= 1'b0;
          end
        HIGH:
          if (hcnt > 8'(HIGH_MAX)) begin
            rx.bit_err <= 1'b1;
            state      <= SYNC;
            lcnt       <= '0;
          end else if (fall) begin
            // short pulses are noise: resume the interrupted low state, lcnt untouched
            if (hcnt <= 8'(GLITCH_MAX)) state <= from_low ? LOW : IDLE;
            else begin
              sr    <= {sr[21:0], b};
              lcnt  <= '0;
              state <= LOW;
              if (bit_cnt == 5'd23) begin
                rx.px_data  <= {sr, b};
                rx.px_valid <= 1'b1;
                rx.px_num   <= pcnt;
                pcnt        <= pcnt + 8'(pcnt != 8'hff);
                bit_cnt     <= '0;
              end else bit_cnt <= bit_cnt + 5'd1;
            end
          end else hcnt <= hcnt + 8'(hcnt != 8'hff);
        LOW:
          if (rise) begin
            state    <= HIGH;
            hcnt     <= 8'd1;
            from_low <= 1'b1;
          end else if (lcnt == 16'(LATCH_CYCLES)) begin
            rx.frame_done <= 1'b1;
            rx.bit_err    <= bit_cnt != 5'd0;
            state         <= IDLE;
            bit_cnt       <= '0;
            pcnt          <= '0;
          end else lcnt <= lcnt + 16'd1;
        default: state <= SYNC;
      endcase
    end
endmodule
